// File: rtl/cdc_arb_pkg.sv
// Shared types and constants for the CDC IN-stream round-robin arbiter.
// Used by cdc_in_arbiter; the TAG state is only reachable with CDC_ARB_TAG_EN.
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAG   = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  localparam logic [3:0] TAG_PREFIX = 4'hA;
  localparam int         N_REQ_MAX  = 8;

  // Header byte announcing which requester owns the following burst.
  function automatic logic [7:0] tag_byte(input logic [$clog2(N_REQ_MAX)-1:0] idx);
    return {TAG_PREFIX, 1'b0, idx};
  endfunction

endpackage

// File: rtl/cdc_in_arbiter_if.sv
// Requester lanes plus the single usb_cdc IN byte stream, grouped for the arbiter.
// slave = arbiter side, master = requesters / usb_cdc side.
interface cdc_in_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [8*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]   req_valid_i;
  logic [N_REQ-1:0]   req_ready_o;
  logic [7:0]         in_data_o;
  logic               in_valid_o;
  logic               in_ready_i;
  logic [N_REQ-1:0]   grant_o;
  logic               busy_o;

  modport master (
    output req_data_i, req_valid_i, in_ready_i,
    input  req_ready_o, in_data_o, in_valid_o, grant_o, busy_o
  );

  modport slave (
    input  req_data_i, req_valid_i, in_ready_i,
    output req_ready_o, in_data_o, in_valid_o, grant_o, busy_o
  );
endinterface

// File: rtl/cdc_in_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Returns the winner one-hot, its index, and whether any request was set.
module cdc_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  function automatic int wrap_idx(input int p, input int i);
    return (p + i) % N_REQ;
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[wrap_idx(int'(ptr), i)]) begin
        any                         = 1'b1;
        gnt[wrap_idx(int'(ptr), i)] = 1'b1;
        idx                         = IW'(wrap_idx(int'(ptr), i));
      end
    end
  end

endmodule

// File: rtl/cdc_in_arbiter.sv
// Round-robin arbiter sharing the usb_cdc IN byte stream among N_REQ producers.
// Define CDC_ARB_TAG_EN to prefix every burst with a {4'hA,0,idx} header byte.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// TAG   | owner chosen; waiting for a free slot to emit the header byte
// BURST | owner streams up to MAX_BURST bytes through the output register
module cdc_in_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8
) (
  input logic              clk_i,
  input logic              rstn_i,
  cdc_in_arbiter_if.slave  bus
);

  localparam int             IW       = $clog2(N_REQ);
  localparam int             CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [N_REQ-1:0] req_ready;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             slot_free;
  logic             own_valid;
  logic [7:0]       own_data;
  logic [7:0]       lanes [N_REQ];

  cdc_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req (bus.req_valid_i),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      lanes[k] = bus.req_data_i[8*k +: 8];
    end
  end

  assign slot_free = ~out_valid_q | bus.in_ready_i;
  assign own_valid = bus.req_valid_i[idx_q];
  assign own_data  = lanes[idx_q];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q & ~bus.in_ready_i;
    out_data_d  = out_valid_d ? out_data_q : 8'h00;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
`ifdef CDC_ARB_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_BURST;
`endif
        end
      end
`ifdef CDC_ARB_TAG_EN
      ST_TAG: begin
        if (slot_free) begin
          out_data_d  = tag_byte(3'(idx_q));
          out_valid_d = 1'b1;
          state_d     = ST_BURST;
        end
      end
`endif
      ST_BURST: begin
        req_ready = grant_q & {N_REQ{slot_free}};
        if (slot_free) begin
          if (own_valid) begin
            out_data_d  = own_data;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            if (cnt_d == CNT_LAST) begin
              state_d = ST_IDLE;
              grant_d = '0;
            end
          end else begin
            // Owner ran dry: give the stream back rather than stall it.
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      idx_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.grant_o     = grant_q;
  assign bus.in_data_o   = out_data_q;
  assign bus.in_valid_o  = out_valid_q;
  assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Randomized bench for cdc_in_arbiter with a queue-based reference model and
// directed scenarios pinned by literal expectations.
module tb_cdc_in_arbiter;
  localparam int N  = 4;
  localparam int MB = 8;
`ifdef CDC_ARB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic clk_48MHz = 1'b0;
  logic rstn      = 1'b0;

  cdc_in_arbiter_if #(.N_REQ(N)) bus ();

  cdc_in_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk_i  (clk_48MHz),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk_48MHz = ~clk_48MHz;

  int total = 0;
  int bad   = 0;

  // model state
  bit         m_busy, m_tagp, m_ov;
  int         m_owner, m_cnt, m_ptr;
  logic [7:0] m_od;
  logic [7:0] exp_q [$];

  // requester drivers
  logic [7:0] q [N][$];
  bit         vld [N];
  bit         acc [N];
  int         p_valid, p_ready;

  // observations
  logic [7:0] out_log [$];
  int         gnt_log [$];
  int         blen_log [$];
  int         gap_log [$];
  int         blen_cur, gap_cur;
  bit         seen_burst;
  logic [N-1:0] prev_gnt;
  bit         pv, pr;
  logic [7:0] pd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic check_cycle();
    bit         free;
    logic [N-1:0] exp_gnt, exp_rdy;
    free    = !m_ov || bus.in_ready_i;
    exp_gnt = m_busy ? (N'(1) << m_owner) : '0;
    exp_rdy = (m_busy && !m_tagp && free) ? exp_gnt : '0;
    chk("grant", bus.grant_o, exp_gnt);
    chk("busy", bus.busy_o, m_busy);
    chk("req_ready", bus.req_ready_o, exp_rdy);
    chk("in_valid", bus.in_valid_o, m_ov);
    if (m_ov) chk("in_data", bus.in_data_o, m_od);
    if (pv && !pr) chk("in_data_hold", bus.in_data_o, pd);
    if (bus.in_valid_o && bus.in_ready_i) begin
      out_log.push_back(bus.in_data_o);
      if (exp_q.size() == 0) chk("sb_unexpected_byte", exp_q.size(), 32'd1);
      else chk("sb_byte", bus.in_data_o, exp_q.pop_front());
    end
    for (int k = 0; k < N; k++)
      if (bus.req_valid_i[k] && bus.req_ready_o[k]) blen_cur++;
    if (bus.grant_o != '0 && prev_gnt == '0) begin
      gnt_log.push_back(onehot_idx(bus.grant_o));
      if (seen_burst) gap_log.push_back(gap_cur);
    end
    if (bus.grant_o == '0 && prev_gnt != '0) begin
      blen_log.push_back(blen_cur);
      blen_cur   = 0;
      seen_burst = 1'b1;
      gap_cur    = 0;
    end
    if (bus.grant_o == '0) gap_cur++;
    pv       = bus.in_valid_o;
    pr       = bus.in_ready_i;
    pd       = bus.in_data_o;
    prev_gnt = bus.grant_o;
  endtask

  // Rules: pick first valid from the rotating pointer, optional header, then
  // one byte per free slot until MAX_BURST bytes or the owner goes quiet.
  task automatic model_advance();
    bit         free, load;
    logic [7:0] lb;
    int         w;
    free = !m_ov || bus.in_ready_i;
    load = 1'b0;
    lb   = 8'h00;
    for (int k = 0; k < N; k++) acc[k] = 1'b0;
    if (!m_busy) begin
      w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && bus.req_valid_i[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_cnt   = 0;
        m_tagp  = TAG_EN;
      end
    end else if (m_tagp) begin
      if (free) begin
        load   = 1'b1;
        lb     = {4'hA, 1'b0, 3'(m_owner)};
        m_tagp = 1'b0;
      end
    end else if (free) begin
      if (bus.req_valid_i[m_owner]) begin
        load         = 1'b1;
        lb           = bus.req_data_i[8*m_owner +: 8];
        acc[m_owner] = 1'b1;
        m_cnt++;
        if (m_cnt == MB) m_busy = 1'b0;
      end else begin
        m_busy = 1'b0;
      end
    end
    if (load) begin
      m_ov = 1'b1;
      m_od = lb;
      exp_q.push_back(lb);
    end else if (m_ov && bus.in_ready_i) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        void'(q[k].pop_front());
        vld[k] = 1'b0;
        acc[k] = 1'b0;
      end
      if (!vld[k] && q[k].size() > 0 && int'($urandom_range(99)) < p_valid) vld[k] = 1'b1;
      bus.req_valid_i[k]       = vld[k];
      bus.req_data_i[8*k +: 8] = vld[k] ? q[k][0] : 8'($urandom);
    end
    bus.in_ready_i = (int'($urandom_range(99)) < p_ready);
  endtask

  task automatic step();
    @(negedge clk_48MHz);
    check_cycle();
    model_advance();
    @(posedge clk_48MHz);
    #1;
    drive();
  endtask

  function automatic bit all_idle();
    bit r = !m_busy && !m_ov && (exp_q.size() == 0);
    for (int k = 0; k < N; k++) if (q[k].size() != 0 || vld[k]) r = 1'b0;
    return r;
  endfunction

  task automatic run_until_idle(input int bound);
    int n = 0;
    while (!all_idle() && n < bound) begin
      step();
      n++;
    end
    if (!all_idle()) begin
      total++;
      bad++;
      $display("FAIL timeout_idle: still busy after %0d cycles, required idle", bound);
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    rstn             = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_data_i   = '0;
    bus.in_ready_i   = 1'b0;
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      vld[k] = 1'b0;
      acc[k] = 1'b0;
    end
    m_busy = 0; m_tagp = 0; m_ov = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_od = 8'h00;
    exp_q.delete();
    out_log.delete(); gnt_log.delete(); blen_log.delete(); gap_log.delete();
    blen_cur = 0; gap_cur = 0; seen_burst = 0; prev_gnt = '0; pv = 0; pr = 0; pd = 8'h00;
    repeat (3) @(posedge clk_48MHz);
    #1;
    chk("rst_in_valid", bus.in_valid_o, 0);
    chk("rst_in_data", bus.in_data_o, 8'h00);
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    rstn = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_len [$];
    int exp_gnt [$];
    logic [7:0] exp_out [$];
    int n;

    // idle after reset
    do_reset();
    p_valid = 0; p_ready = 100;
    drive();
    repeat (100) step();
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_grant", bus.grant_o, 0);

    // requester 1, 20 bytes, continuous ready
    do_reset();
    for (int b = 0; b < 20; b++) q[1].push_back(8'(b));
    p_valid = 100; p_ready = 100;
    drive();
    run_until_idle(300);
    exp_len = '{8, 8, 4};
    chk("t1_nbursts", blen_log.size(), 3);
    for (int i = 0; i < 3 && i < blen_log.size(); i++) chk("t1_burst_len", blen_log[i], exp_len[i]);
    for (int i = 0; i < gnt_log.size(); i++) chk("t1_grant_idx", gnt_log[i], 1);
    chk("t1_ngaps", gap_log.size(), 2);
    for (int i = 0; i < gap_log.size(); i++) chk("t1_idle_gap", gap_log[i], 1);
    exp_out.delete();
    for (int b = 0; b < 20; b++) begin
      if (TAG_EN && (b % MB) == 0) exp_out.push_back(8'hA1);
      exp_out.push_back(8'(b));
    end
    chk("t1_nbytes", out_log.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < out_log.size(); i++) chk("t1_byte", out_log[i], exp_out[i]);

    // all requesters continuously valid: strict rotation
    do_reset();
    for (int k = 0; k < N; k++)
      for (int b = 0; b < 16; b++) q[k].push_back(8'((k << 4) | b));
    p_valid = 100; p_ready = 100;
    drive();
    run_until_idle(600);
    exp_gnt = '{0, 1, 2, 3, 0};
    chk("t2_ngrants", gnt_log.size(), 8);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("t2_rotation", gnt_log[i], exp_gnt[i]);
    for (int i = 0; i < blen_log.size(); i++) chk("t2_burst_len", blen_log[i], MB);

    // requester 2 stops after 3 bytes, requester 3 waiting
    do_reset();
    q[2] = '{8'h20, 8'h21, 8'h22};
    q[3] = '{8'h30, 8'h31};
    p_valid = 100; p_ready = 100;
    drive();
    run_until_idle(200);
    chk("t3_ngrants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("t3_first_grant", gnt_log[0], 2);
      chk("t3_next_grant", gnt_log[1], 3);
    end
    if (blen_log.size() == 2) begin
      chk("t3_len_req2", blen_log[0], 3);
      chk("t3_len_req3", blen_log[1], 2);
    end

    // randomized traffic with a 50% ready duty
    do_reset();
    n = 0;
    for (int k = 0; k < N; k++)
      for (int b = 0; b < 40; b++) begin
        q[k].push_back(8'($urandom));
        n++;
      end
    p_valid = 60; p_ready = 50;
    drive();
    run_until_idle(20000);
    chk("t4_total_bytes", out_log.size(), n + (TAG_EN ? gnt_log.size() : 0));
    for (int i = 0; i < blen_log.size(); i++) chk("t4_burst_le_max", blen_log[i] <= MB, 1);

`ifdef CDC_ARB_TAG_EN
    // header then data for requester 3
    do_reset();
    q[3].push_back(8'h55);
    p_valid = 100; p_ready = 100;
    drive();
    run_until_idle(100);
    chk("t5_nbytes", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("t5_tag", out_log[0], 8'hA3);
      chk("t5_data", out_log[1], 8'h55);
    end
`endif

    // reset while a byte sits in the output register
    do_reset();
    q[0] = '{8'h77, 8'h78};
    p_valid = 100; p_ready = 0;
    drive();
    n = 0;
    while (!bus.in_valid_o && n < 20) begin
      step();
      n++;
    end
    chk("t6_loaded", bus.in_valid_o, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_in_valid", bus.in_valid_o, 0);
    chk("t6_async_grant", bus.grant_o, 0);
    chk("t6_async_busy", bus.busy_o, 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
